pipelined_cla_adder: RTL and testbench

- Parametrised, pipelined carry-lookahead adder/subtractor; successor to the fixed 4-bit CLA.
- Operand width, lookahead group size and pipeline depth are all parameters.
- Adds a subtract mode, overflow/zero flags and a valid/ready handshake with backpressure on both sides.
- Sits in the execute stage as the ALU add/sub datapath and as the branch-target adder.

---
 rtl/cla_pkg.sv | 25 ++
 rtl/cla_group.sv | 61 ++++++
 rtl/pipelined_cla_adder.sv | 194 +++++++++++++++++++
 tb/tb_pipelined_cla_adder.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared sizing helpers for the pipelined carry-lookahead adder.
package cla_pkg;

  // Ceiling division, used to spread lookahead groups evenly over stages.
  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  // Number of lookahead groups across the operand.
  function automatic int n_groups(input int width, input int group);
    return width / group;
  endfunction

  // Groups handled by each pipeline stage (the last stage may get fewer).
  function automatic int groups_per_stage(input int width, input int group, input int stages);
    return ceil_div(width / group, stages);
  endfunction

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_GROUP  = 4;
  localparam int DEFAULT_STAGES = 2;
  localparam int NGROUPS        = n_groups(DEFAULT_WIDTH, DEFAULT_GROUP);
  localparam int K              = ceil_div(NGROUPS, DEFAULT_STAGES);

endpackage

// File: rtl/cla_group.sv
// Combinational GROUP-bit carry-lookahead block with group generate/propagate.
module cla_group #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] sum,
  output logic             g,
  output logic             p
);

  logic [GROUP-1:0] bit_g;
  logic [GROUP-1:0] bit_p;
  logic [GROUP-1:0] carry;
  logic             c_acc;
  logic             c_term;
  logic             c_chain;
  logic             g_term;

  assign bit_g = a & b;
  assign bit_p = a ^ b;

  // Every bit carry is a flat sum of products of g/p terms and cin, so no bit-to-bit ripple.
  always_comb begin
    carry   = '0;
    c_acc   = 1'b0;
    c_term  = 1'b0;
    c_chain = 1'b0;
    for (int i = 0; i < GROUP; i++) begin
      c_chain = cin;
      c_acc   = 1'b0;
      for (int j = 0; j < i; j++) begin
        c_chain = c_chain & bit_p[j];
        c_term  = bit_g[j];
        for (int k = j + 1; k < i; k++) begin
          c_term = c_term & bit_p[k];
        end
        c_acc = c_acc | c_term;
      end
      carry[i] = c_acc | c_chain;
    end
  end

  // Group generate: some bit generates and every bit above it propagates.
  always_comb begin
    g      = 1'b0;
    g_term = 1'b0;
    for (int j = 0; j < GROUP; j++) begin
      g_term = bit_g[j];
      for (int k = j + 1; k < GROUP; k++) begin
        g_term = g_term & bit_p[k];
      end
      g = g | g_term;
    end
  end

  assign p   = &bit_p;
  assign sum = bit_p ^ carry;

endmodule

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor with valid/ready on both sides.
// Each stage resolves a contiguous slice of groups and passes the carry on.
module pipelined_cla_adder
  import cla_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int GROUP  = DEFAULT_GROUP,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int NG   = n_groups(WIDTH, GROUP);
  localparam int KS   = groups_per_stage(WIDTH, GROUP, STAGES);
  localparam int LAST = STAGES - 1;

  if (WIDTH % GROUP != 0) begin : g_bad_width
    $fatal(1, "pipelined_cla_adder: WIDTH must be a multiple of GROUP");
  end
  if (STAGES < 1 || STAGES > NG) begin : g_bad_stages
    $fatal(1, "pipelined_cla_adder: STAGES must be within 1..WIDTH/GROUP");
  end

  // Stage registers
  logic             v_reg  [STAGES];
  logic [WIDTH-1:0] a_reg  [STAGES];
  logic [WIDTH-1:0] b_reg  [STAGES];
  logic [WIDTH-1:0] s_reg  [STAGES];
  logic             c_reg  [STAGES];
  logic             sa_reg [STAGES];
  logic             sb_reg [STAGES];
  logic             ov_reg;
  logic             z_reg;

  // What each stage consumes (input port for stage 0, previous register otherwise)
  logic             src_v  [STAGES];
  logic [WIDTH-1:0] src_a  [STAGES];
  logic [WIDTH-1:0] src_b  [STAGES];
  logic [WIDTH-1:0] src_s  [STAGES];
  logic             src_c  [STAGES];
  logic             src_sa [STAGES];
  logic             src_sb [STAGES];
  logic [WIDTH-1:0] nxt_s  [STAGES];
  logic             nxt_c  [STAGES];
  logic             en     [STAGES];

  logic [GROUP-1:0] grp_sum  [NG];
  logic             grp_g    [NG];
  logic             grp_p    [NG];
  logic             grp_cin  [NG];
  logic             grp_cout [NG];

  logic [WIDTH-1:0] b_eff;
  logic             c0;
  logic             ov_next;
  logic             z_next;
  logic             unused_ok;

  assign b_eff = sub ? ~b : b;
  assign c0    = sub ? 1'b1 : cin;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    localparam int LO     = gi * KS;
    localparam int HI_END = ((gi + 1) * KS < NG) ? (gi + 1) * KS : NG;
    localparam int HI     = HI_END - 1;

    if (gi == 0) begin : g_src_in
      assign src_v[gi]  = in_valid;
      assign src_a[gi]  = a;
      assign src_b[gi]  = b_eff;
      assign src_s[gi]  = '0;
      assign src_c[gi]  = c0;
      assign src_sa[gi] = a[WIDTH-1];
      assign src_sb[gi] = b_eff[WIDTH-1];
    end else begin : g_src_reg
      assign src_v[gi]  = v_reg[gi-1];
      assign src_a[gi]  = a_reg[gi-1];
      assign src_b[gi]  = b_reg[gi-1];
      assign src_s[gi]  = s_reg[gi-1];
      assign src_c[gi]  = c_reg[gi-1];
      assign src_sa[gi] = sa_reg[gi-1];
      assign src_sb[gi] = sb_reg[gi-1];
    end

    // A stage with no groups of its own just forwards the carry.
    if (LO > HI) begin : g_pass_carry
      assign nxt_c[gi] = src_c[gi];
    end else begin : g_stage_carry
      assign nxt_c[gi] = grp_cout[HI];
    end

    for (genvar bi = 0; bi < WIDTH; bi++) begin : g_bit
      if ((bi / GROUP) >= LO && (bi / GROUP) <= HI) begin : g_new
        assign nxt_s[gi][bi] = grp_sum[bi / GROUP][bi % GROUP];
      end else begin : g_keep
        assign nxt_s[gi][bi] = src_s[gi][bi];
      end
    end

    // A register may load when it is empty or its content moves on this cycle.
    if (gi == LAST) begin : g_en_last
      assign en[gi] = !v_reg[gi] | out_ready;
    end else begin : g_en_mid
      assign en[gi] = !v_reg[gi] | en[gi+1];
    end
  end

  for (genvar gi = 0; gi < NG; gi++) begin : g_grp
    localparam int ST = gi / KS;

    // First group of a stage takes the stage carry; the rest use group lookahead.
    if (gi % KS == 0) begin : g_cin_stage
      assign grp_cin[gi] = src_c[ST];
    end else begin : g_cin_look
      assign grp_cin[gi] = grp_cout[gi-1];
    end

    cla_group #(.GROUP(GROUP)) u_group (
      .a   (src_a[ST][gi*GROUP +: GROUP]),
      .b   (src_b[ST][gi*GROUP +: GROUP]),
      .cin (grp_cin[gi]),
      .sum (grp_sum[gi]),
      .g   (grp_g[gi]),
      .p   (grp_p[gi])
    );

    assign grp_cout[gi] = grp_g[gi] | (grp_p[gi] & grp_cin[gi]);
  end

  assign ov_next = (src_sa[LAST] == src_sb[LAST]) & (nxt_s[LAST][WIDTH-1] != src_sa[LAST]);
  assign z_next  = (nxt_s[LAST] == '0);

  // Advance the pipeline; stalled stages hold, empty stages fill behind a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        v_reg[i]  <= 1'b0;
        a_reg[i]  <= '0;
        b_reg[i]  <= '0;
        s_reg[i]  <= '0;
        c_reg[i]  <= 1'b0;
        sa_reg[i] <= 1'b0;
        sb_reg[i] <= 1'b0;
      end
      ov_reg <= 1'b0;
      z_reg  <= 1'b0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (en[i]) begin
          v_reg[i]  <= src_v[i];
          a_reg[i]  <= src_a[i];
          b_reg[i]  <= src_b[i];
          s_reg[i]  <= nxt_s[i];
          c_reg[i]  <= nxt_c[i];
          sa_reg[i] <= src_sa[i];
          sb_reg[i] <= src_sb[i];
        end
      end
      if (en[LAST]) begin
        ov_reg <= ov_next;
        z_reg  <= z_next;
      end
    end
  end

  // Operand bits of already-summed groups are carried but never read downstream.
  always_comb begin
    unused_ok = 1'b0;
    for (int i = 0; i < STAGES; i++) begin
      unused_ok = unused_ok ^ (^a_reg[i]) ^ (^b_reg[i]) ^ sa_reg[i] ^ sb_reg[i];
    end
  end

  assign in_ready  = en[0];
  assign out_valid = v_reg[LAST];
  assign sum       = s_reg[LAST];
  assign cout      = c_reg[LAST];
  assign overflow  = ov_reg;
  assign zero      = z_reg;

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Bench for pipelined_cla_adder: directed checks on the default build plus a
// randomized scoreboard run over four parameter sets.
module tb_pipelined_cla_adder;

  localparam int NI = 4;

  typedef struct packed {
    logic [63:0] sum;
    logic        cout;
    logic        ov;
    logic        z;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid_s  [NI];
  logic        out_ready_s [NI];
  logic        cin_s       [NI];
  logic        sub_s       [NI];
  logic [63:0] a_s         [NI];
  logic [63:0] b_s         [NI];
  logic        in_ready_s  [NI];
  logic        out_valid_s [NI];
  logic        cout_s      [NI];
  logic        ov_s        [NI];
  logic        z_s         [NI];
  logic [63:0] sum_s       [NI];
  logic [31:0] sum0;
  logic [7:0]  sum1;
  logic [31:0] sum2;

  res_t exp_q [NI][$];
  int   compared = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  pipelined_cla_adder u_dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[0]), .in_ready(in_ready_s[0]),
    .a(a_s[0][31:0]), .b(b_s[0][31:0]), .cin(cin_s[0]), .sub(sub_s[0]),
    .out_valid(out_valid_s[0]), .out_ready(out_ready_s[0]), .sum(sum0),
    .cout(cout_s[0]), .overflow(ov_s[0]), .zero(z_s[0])
  );

  pipelined_cla_adder #(.WIDTH(8), .GROUP(4), .STAGES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[1]), .in_ready(in_ready_s[1]),
    .a(a_s[1][7:0]), .b(b_s[1][7:0]), .cin(cin_s[1]), .sub(sub_s[1]),
    .out_valid(out_valid_s[1]), .out_ready(out_ready_s[1]), .sum(sum1),
    .cout(cout_s[1]), .overflow(ov_s[1]), .zero(z_s[1])
  );

  pipelined_cla_adder #(.WIDTH(32), .GROUP(4), .STAGES(8)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[2]), .in_ready(in_ready_s[2]),
    .a(a_s[2][31:0]), .b(b_s[2][31:0]), .cin(cin_s[2]), .sub(sub_s[2]),
    .out_valid(out_valid_s[2]), .out_ready(out_ready_s[2]), .sum(sum2),
    .cout(cout_s[2]), .overflow(ov_s[2]), .zero(z_s[2])
  );

  pipelined_cla_adder #(.WIDTH(64), .GROUP(8), .STAGES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s[3]), .in_ready(in_ready_s[3]),
    .a(a_s[3]), .b(b_s[3]), .cin(cin_s[3]), .sub(sub_s[3]),
    .out_valid(out_valid_s[3]), .out_ready(out_ready_s[3]), .sum(sum_s[3]),
    .cout(cout_s[3]), .overflow(ov_s[3]), .zero(z_s[3])
  );

  assign sum_s[0] = {32'b0, sum0};
  assign sum_s[1] = {56'b0, sum1};
  assign sum_s[2] = {32'b0, sum2};

  function automatic int width_of(input int idx);
    case (idx)
      1:       return 8;
      3:       return 64;
      default: return 32;
    endcase
  endfunction

  function automatic logic [63:0] mask_of(input int w);
    if (w == 64) return '1;
    return (64'd1 << w) - 64'd1;
  endfunction

  // Reference: unsigned result from wide arithmetic, overflow from the true signed value.
  function automatic res_t ref_model(input int w, input logic [63:0] a_in, input logic [63:0] b_in,
                                     input logic cin_in, input logic sub_in);
    res_t               r;
    logic [63:0]        m, av, bv;
    logic [64:0]        full;
    logic signed [66:0] sa, sb, st, lim;
    m  = mask_of(w);
    av = a_in & m;
    bv = b_in & m;
    if (sub_in) full = {1'b0, av} - {1'b0, bv} + (65'd1 << w);
    else        full = {1'b0, av} + {1'b0, bv} + {64'd0, cin_in};
    r.sum  = full[63:0] & m;
    r.cout = full[w];
    r.z    = (r.sum == 64'd0);
    sa = $signed({3'b0, av});
    sb = $signed({3'b0, bv});
    if (av[w-1]) sa = sa - (67'sd1 <<< w);
    if (bv[w-1]) sb = sb - (67'sd1 <<< w);
    st   = sub_in ? (sa - sb) : (sa + sb + $signed({66'd0, cin_in}));
    lim  = 67'sd1 <<< (w - 1);
    r.ov = (st >= lim) || (st < -lim);
    return r;
  endfunction

  function automatic res_t obs(input int idx);
    res_t r;
    r.sum  = sum_s[idx];
    r.cout = cout_s[idx];
    r.ov   = ov_s[idx];
    r.z    = z_s[idx];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [66:0] observed, input logic [66:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic drive0(input logic [31:0] av, input logic [31:0] bv, input logic cv, input logic sv);
    a_s[0]   = {32'b0, av};
    b_s[0]   = {32'b0, bv};
    cin_s[0] = cv;
    sub_s[0] = sv;
  endtask

  // One beat through the idle default instance, checking exact latency.
  task automatic beat0(input logic [31:0] av, input logic [31:0] bv, input logic cv,
                       input logic sv, input string tag);
    res_t e;
    e = ref_model(32, {32'b0, av}, {32'b0, bv}, cv, sv);
    drive0(av, bv, cv, sv);
    in_valid_s[0]  = 1'b1;
    out_ready_s[0] = 1'b1;
    #1;
    chk({tag, "_in_ready"}, in_ready_s[0], 1'b1);
    @(posedge clk); #1;
    in_valid_s[0] = 1'b0;
    chk({tag, "_lat1_valid"}, out_valid_s[0], 1'b0);
    @(posedge clk); #1;
    chk({tag, "_lat2_valid"}, out_valid_s[0], 1'b1);
    chk({tag, "_result"}, obs(0), e);
    $display("beat %s a=%h b=%h cin=%0b sub=%0b -> sum=%h cout=%0b ov=%0b z=%0b",
             tag, av, bv, cv, sv, sum_s[0][31:0], cout_s[0], ov_s[0], z_s[0]);
    @(posedge clk); #1;
    chk({tag, "_drained"}, out_valid_s[0], 1'b0);
  endtask

  initial begin
    res_t ex, ey, ez, e;
    for (int i = 0; i < NI; i++) begin
      in_valid_s[i]  = 1'b0;
      out_ready_s[i] = 1'b1;
      cin_s[i]       = 1'b0;
      sub_s[i]       = 1'b0;
      a_s[i]         = '0;
      b_s[i]         = '0;
    end

    // Reset held with random traffic on the inputs
    rst_n = 1'b0;
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NI; i++) begin
        in_valid_s[i]  = 1'b1;
        out_ready_s[i] = 1'($urandom_range(0, 1));
        a_s[i]         = {$urandom, $urandom};
        b_s[i]         = {$urandom, $urandom};
        cin_s[i]       = 1'($urandom_range(0, 1));
        sub_s[i]       = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      chk("rst_out_valid", out_valid_s[0], 1'b0);
      chk("rst_outputs", obs(0), 67'd0);
    end
    for (int i = 0; i < NI; i++) begin
      in_valid_s[i]  = 1'b0;
      out_ready_s[i] = 1'b1;
    end
    rst_n = 1'b1;
    #1;
    chk("post_rst_in_ready", in_ready_s[0], 1'b1);
    @(posedge clk); #1;

    // Directed arithmetic cases
    beat0(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, "wrap");
    beat0(32'h5, 32'h7, 1'b1, 1'b1, "sub_borrow");
    beat0(32'h7, 32'h7, 1'b1, 1'b1, "sub_equal");
    beat0(32'h9, 32'h3, 1'b0, 1'b1, "sub_cin0");
    beat0(32'h9, 32'h3, 1'b1, 1'b1, "sub_cin1");
    beat0(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, "ovf_add");
    beat0(32'h8000_0000, 32'h1, 1'b0, 1'b1, "ovf_sub");
    beat0(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 1'b0, "add_cin");

    // Backpressure: two beats fill the pipe, the third waits for a drain
    ex = ref_model(32, 64'h11, 64'h22, 1'b0, 1'b0);
    ey = ref_model(32, 64'hFFFF_0000, 64'h0001_0000, 1'b0, 1'b0);
    ez = ref_model(32, 64'h100, 64'h1, 1'b0, 1'b1);
    out_ready_s[0] = 1'b0;
    in_valid_s[0]  = 1'b1;
    drive0(32'h11, 32'h22, 1'b0, 1'b0);
    #1;
    chk("bp_ready_x", in_ready_s[0], 1'b1);
    @(posedge clk); #1;
    drive0(32'hFFFF_0000, 32'h0001_0000, 1'b0, 1'b0);
    chk("bp_ready_y", in_ready_s[0], 1'b1);
    chk("bp_valid_early", out_valid_s[0], 1'b0);
    @(posedge clk); #1;
    drive0(32'h100, 32'h1, 1'b0, 1'b1);
    chk("bp_full_ready", in_ready_s[0], 1'b0);
    chk("bp_hold_valid", out_valid_s[0], 1'b1);
    chk("bp_hold_x1", obs(0), ex);
    @(posedge clk); #1;
    chk("bp_stall_ready", in_ready_s[0], 1'b0);
    chk("bp_hold_x2", obs(0), ex);
    $display("stall beat X held sum=%h", sum_s[0][31:0]);
    out_ready_s[0] = 1'b1;
    #1;
    chk("bp_release_ready", in_ready_s[0], 1'b1);
    @(posedge clk); #1;
    in_valid_s[0] = 1'b0;
    chk("bp_result_y", obs(0), ey);
    $display("drain beat Y sum=%h", sum_s[0][31:0]);
    @(posedge clk); #1;
    chk("bp_valid_z", out_valid_s[0], 1'b1);
    chk("bp_result_z", obs(0), ez);
    $display("drain beat Z sum=%h", sum_s[0][31:0]);
    @(posedge clk); #1;
    chk("bp_empty", out_valid_s[0], 1'b0);

    // Reset with two beats in flight flushes them
    in_valid_s[0] = 1'b1;
    drive0(32'hA, 32'hB, 1'b0, 1'b0);
    @(posedge clk); #1;
    drive0(32'hC, 32'hD, 1'b0, 1'b0);
    @(posedge clk); #1;
    in_valid_s[0] = 1'b0;
    chk("midrst_inflight", out_valid_s[0], 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_flush_valid", out_valid_s[0], 1'b0);
    chk("midrst_flush_out", obs(0), 67'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int r = 0; r < 4; r++) begin
      @(posedge clk); #1;
      chk("midrst_no_output", out_valid_s[0], 1'b0);
    end
    beat0(32'h0000_FFFF, 32'h0000_0001, 1'b0, 1'b0, "post_rst");

    // Random scoreboard run on all four builds, ending with a drain
    for (int cyc = 0; cyc < 800; cyc++) begin
      for (int i = 0; i < NI; i++) begin
        in_valid_s[i]  = (cyc < 750) && ($urandom_range(0, 3) != 0);
        out_ready_s[i] = (cyc >= 750) || ($urandom_range(0, 3) != 0);
        a_s[i]         = {$urandom, $urandom} & mask_of(width_of(i));
        b_s[i]         = {$urandom, $urandom} & mask_of(width_of(i));
        if ($urandom_range(0, 7) == 0) b_s[i] = a_s[i];
        cin_s[i]       = 1'($urandom_range(0, 1));
        sub_s[i]       = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (out_valid_s[i] && out_ready_s[i]) begin
          if (exp_q[i].size() == 0) begin
            chk($sformatf("sweep%0d_spurious", i), out_valid_s[i], 1'b0);
          end else begin
            e = exp_q[i].pop_front();
            chk($sformatf("sweep%0d_result", i), obs(i), e);
            if (cyc % 100 == 0)
              $display("sweep%0d cyc=%0d sum=%h cout=%0b ov=%0b z=%0b",
                       i, cyc, sum_s[i], cout_s[i], ov_s[i], z_s[i]);
          end
        end
        if (in_valid_s[i] && in_ready_s[i])
          exp_q[i].push_back(ref_model(width_of(i), a_s[i], b_s[i], cin_s[i], sub_s[i]));
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("sweep%0d_drained", i), exp_q[i].size(), 67'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
